// File: rtl/opb_seed_bank_ctrl.sv
// OPB seed register bank: snapshots up to 16 seed words on commit and streams them one per valid/ready handshake.
// Optional macro SEED_AUTO_COMMIT_EN: a write to the last seed register also acts as a commit.
module opb_seed_bank_ctrl #(
  parameter logic [31:0] C_BASEADDR = 32'h01080000,
  parameter logic [31:0] C_HIGHADDR = 32'h010800FF,
  parameter int          N_SEEDS    = 4
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] seed_data,
  output logic [3:0]  seed_idx,
  output logic        seed_valid,
  input  logic        seed_ready,
  output logic        busy
);
  localparam logic [5:0] W_CTRL    = 6'd16;
  localparam logic [5:0] W_STATUS  = 6'd17;
  localparam logic [5:0] LAST_WORD = 6'(N_SEEDS - 1);
  localparam logic [3:0] LAST_IDX  = 4'(N_SEEDS - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;
  state_t state_q, state_d;

  logic [31:0] abus, dbus, addr_off;
  logic [3:0]  be;
  logic [5:0]  word;
  logic        hit, start;

  logic        ack_q, ack_d;
  logic        wr_q, wr_d;
  logic [5:0]  word_q, word_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] seed_q   [N_SEEDS];
  logic [31:0] seed_d   [N_SEEDS];
  logic [31:0] shadow_q [N_SEEDS];
  logic [31:0] shadow_d [N_SEEDS];
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ovr_q, ovr_d;
  logic        do_wr, ctrl_wr, commit, clr_ovr;
  logic        unused_ok;

  // Bit 0 of the OPB buses is the MSB, so a plain vector copy gives value-ordered bits.
  assign abus      = OPB_ABus;
  assign dbus      = OPB_DBus;
  assign be        = OPB_BE;
  assign addr_off  = abus - C_BASEADDR;
  assign word      = addr_off[7:2];
  assign hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign start     = hit && !ack_q;
  assign unused_ok = ^{OPB_seqAddr, addr_off[31:8], addr_off[1:0]};

  assign Sl_DBus    = rdat_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // Bus front end: capture the request at the select cycle, act on it at the end of the ack cycle.
  always_comb begin
    ack_d  = start;
    wr_d   = start && !OPB_RNW;
    word_d = word_q;
    wdat_d = wdat_q;
    be_d   = be_q;
    if (start) begin
      word_d = word;
      wdat_d = dbus;
      be_d   = be;
    end
  end

  always_comb begin
    rdat_d = '0;
    if (start && OPB_RNW) begin
      for (int k = 0; k < N_SEEDS; k++) begin
        if (word == 6'(k)) rdat_d = seed_q[k];
      end
      if (word == W_STATUS) rdat_d = {16'h0, cnt_q, 6'h0, ovr_q, state_q == ST_SEND};
    end
  end

  assign do_wr   = ack_q && wr_q;
  assign ctrl_wr = do_wr && (word_q == W_CTRL);
  assign clr_ovr = ctrl_wr && wdat_q[1];
`ifdef SEED_AUTO_COMMIT_EN
  assign commit  = (ctrl_wr && wdat_q[0]) || (do_wr && (word_q == LAST_WORD) && (|be_q));
`else
  assign commit  = ctrl_wr && wdat_q[0];
`endif

  always_comb begin
    for (int k = 0; k < N_SEEDS; k++) begin
      seed_d[k] = seed_q[k];
      if (do_wr && (word_q == 6'(k))) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[b]) seed_d[k][8*b +: 8] = wdat_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (commit) state_d = ST_SEND;
      ST_SEND: if (seed_ready && (idx_q == LAST_IDX)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Snapshot takes seed_d so an auto-commit includes the bytes written on the same edge.
  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ovr_d    = clr_ovr ? 1'b0 : ovr_q;
    if (state_q == ST_IDLE) begin
      if (commit) begin
        shadow_d = seed_d;
        idx_d    = '0;
      end
    end else begin
      if (commit) ovr_d = 1'b1;
      if (seed_ready) begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          cnt_d = cnt_q + 8'd1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    seed_valid = (state_q == ST_SEND);
    busy       = (state_q == ST_SEND);
    seed_idx   = '0;
    seed_data  = '0;
    if (state_q == ST_SEND) begin
      seed_idx = idx_q;
      for (int k = 0; k < N_SEEDS; k++) begin
        if (idx_q == 4'(k)) seed_data = shadow_q[k];
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q  <= 1'b0;
      wr_q   <= 1'b0;
      word_q <= '0;
      wdat_q <= '0;
      be_q   <= '0;
      rdat_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      for (int k = 0; k < N_SEEDS; k++) begin
        seed_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      ack_q  <= ack_d;
      wr_q   <= wr_d;
      word_q <= word_d;
      wdat_q <= wdat_d;
      be_q   <= be_d;
      rdat_q <= rdat_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      for (int k = 0; k < N_SEEDS; k++) begin
        seed_q[k]   <= seed_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

endmodule

// File: tb/tb_opb_seed_bank_ctrl.sv
// Randomized bench for opb_seed_bank_ctrl against a transaction-level model of the register map and load stream.
module tb_opb_seed_bank_ctrl;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h01080000;
`ifdef SEED_AUTO_COMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        OPB_Rst;
  logic [0:31] OPB_ABus, OPB_DBus, Sl_DBus;
  logic [0:3]  OPB_BE;
  logic        OPB_RNW, OPB_select, OPB_seqAddr;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] seed_data;
  logic [3:0]  seed_idx;
  logic        seed_valid, seed_ready, busy;

  opb_seed_bank_ctrl dut (
    .OPB_Clk(clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .seed_data(seed_data), .seed_idx(seed_idx), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents, pending delivery list, counters.
  typedef struct packed {logic [3:0] idx; logic [31:0] dat;} item_t;
  logic [31:0] seed_m [64];
  item_t       load_q [$];
  int          cnt_m;
  bit          ovr_m;
  int          pend_cnt;
  bit          pend_wr;
  logic [5:0]  pend_word;
  logic [31:0] pend_dat;
  logic [3:0]  pend_be;
  bit          mon_en;
  int          ready_mode;

  function automatic void model_reset();
    for (int k = 0; k < 64; k++) seed_m[6'(k)] = '0;
    load_q.delete();
    cnt_m    = 0;
    ovr_m    = 1'b0;
    pend_cnt = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] w);
    if (w < 6'(N)) return seed_m[w];
    if (w == 6'd17) return {16'h0, 8'(cnt_m % 256), 6'h0, ovr_m, load_q.size() != 0};
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [5:0] w, input logic [31:0] d,
                                      input logic [3:0] be, input bit was_busy);
    bit do_commit = 1'b0;
    if (w < 6'(N)) begin
      for (int b = 0; b < 4; b++) if (be[b]) seed_m[w][8*b +: 8] = d[8*b +: 8];
      if (AUTO && w == 6'(N - 1) && be != 4'h0) do_commit = 1'b1;
    end
    if (w == 6'd16) begin
      if (d[1]) ovr_m = 1'b0;
      if (d[0]) do_commit = 1'b1;
    end
    if (do_commit) begin
      if (was_busy) ovr_m = 1'b1;
      else for (int k = 0; k < N; k++) load_q.push_back(item_t'{idx: 4'(k), dat: seed_m[6'(k)]});
    end
  endfunction

  // Per-cycle monitor: ack timing, idle data bus, delivered seed stream, model updates.
  always @(negedge clk) begin
    bit busy_now;
    bit exp_ack;
    if (mon_en) begin
      busy_now = load_q.size() != 0;
      exp_ack  = (pend_cnt == 1);
      chk("xfer_ack", 32'(Sl_xferAck), 32'(exp_ack));
      if (!Sl_xferAck) chk("dbus_idle", Sl_DBus, 32'h0);
      chk("seed_valid", 32'(seed_valid), 32'(busy_now));
      chk("busy", 32'(busy), 32'(busy_now));
      if (busy_now) begin
        chk("seed_idx", 32'(seed_idx), 32'(load_q[0].idx));
        chk("seed_data", seed_data, load_q[0].dat);
        if (seed_ready) begin
          void'(load_q.pop_front());
          if (load_q.size() == 0) cnt_m++;
        end
      end
      if (pend_cnt == 1 && pend_wr) model_write(pend_word, pend_dat, pend_be, busy_now);
      if (pend_cnt > 0) pend_cnt--;
    end
    if (OPB_Rst) model_reset();
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      seed_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 1) seed_ready = 1'b1;
    else if (ready_mode == 2) seed_ready = 1'b0;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic xfer(input bit rnw, input logic [5:0] w, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd);
    logic [31:0] exp;
    OPB_select = 1'b1;
    OPB_RNW    = rnw;
    OPB_ABus   = BASE + {24'h0, w, 2'(rnw ? $urandom_range(0, 3) : 0)};
    OPB_DBus   = d;
    OPB_BE     = be;
    exp        = model_read(w);
    pend_cnt   = 2;
    pend_wr    = !rnw;
    pend_word  = w;
    pend_dat   = d;
    pend_be    = be;
    @(negedge clk);
    @(negedge clk);
    rd = Sl_DBus;
    if (rnw) chk($sformatf("read_w%0d", w), rd, exp);
    @(posedge clk);
    #1;
    OPB_select = 1'b0;
    OPB_RNW    = 1'b1;
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int i = 0; i < 200 && load_q.size() != 0; i++) idle(1);
    idle(1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  w;
    logic [31:0] d;
    int          r;
    OPB_Rst = 1'b1; OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_ABus = '0;
    OPB_DBus = '0; OPB_BE = '0; OPB_seqAddr = 1'b0; seed_ready = 1'b0;
    ready_mode = 1; mon_en = 1'b0; pend_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    OPB_Rst = 1'b0;
    mon_en  = 1'b1;

    chk("rst_seed_valid", 32'(seed_valid), 32'h0);
    xfer(1'b1, 6'd17, 32'h0, 4'hf, rd); chk("rst_status", rd, 32'h0);
    xfer(1'b1, 6'd0,  32'h0, 4'hf, rd); chk("rst_seed0", rd, 32'h0);
    xfer(1'b1, 6'd16, 32'h0, 4'hf, rd); chk("rst_ctrl", rd, 32'h0);

    // Out-of-range selects must never be acknowledged.
    OPB_select = 1'b1; OPB_ABus = BASE + 32'h100; idle(3);
    OPB_ABus = BASE - 32'h4; idle(2);
    OPB_select = 1'b0; idle(1);

    // Basic load, SEED3 written first so an auto-commit load finishes before CTRL.
    xfer(1'b0, 6'd3, 32'h44444444, 4'hf, rd);
    xfer(1'b0, 6'd0, 32'h11111111, 4'hf, rd);
    xfer(1'b0, 6'd1, 32'h22222222, 4'hf, rd);
    xfer(1'b0, 6'd2, 32'h33333333, 4'hf, rd);
    xfer(1'b0, 6'd16, 32'h1, 4'hf, rd);
    drain();
    xfer(1'b1, 6'd17, 32'h0, 4'hf, rd);
    chk("status_after_load", rd, AUTO ? 32'h00000200 : 32'h00000100);

    xfer(1'b0, 6'd2, 32'hAAAABBBB, 4'b0011, rd);
    xfer(1'b1, 6'd2, 32'h0, 4'hf, rd); chk("partial_be", rd, 32'h3333BBBB);

    // Overrun while the consumer stalls.
    ready_mode = 2; idle(1);
    xfer(1'b0, 6'd16, 32'h1, 4'hf, rd);
    xfer(1'b0, 6'd0, 32'hDEADBEEF, 4'hf, rd);
    xfer(1'b0, 6'd16, 32'h1, 4'hf, rd);
    chk("hold_data", seed_data, 32'h11111111);
    xfer(1'b1, 6'd17, 32'h0, 4'hf, rd); chk("ovr_busy_bits", 32'(rd[1:0]), 32'h3);
    xfer(1'b0, 6'd16, 32'h2, 4'hf, rd);
    xfer(1'b1, 6'd17, 32'h0, 4'hf, rd); chk("ovr_cleared", 32'(rd[1]), 32'h0);
    drain();

    // Reset in the middle of a load at k=2.
    ready_mode = 3; seed_ready = 1'b0; idle(1);
    xfer(1'b0, 6'd16, 32'h1, 4'hf, rd);
    seed_ready = 1'b1; idle(2);
    seed_ready = 1'b0;
    chk("pre_rst_idx", 32'(seed_idx), 32'h2);
    OPB_Rst = 1'b1; idle(1); OPB_Rst = 1'b0;
    chk("post_rst_valid", 32'(seed_valid), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    xfer(1'b1, 6'd17, 32'h0, 4'hf, rd); chk("post_rst_status", rd, 32'h0);
    xfer(1'b1, 6'd0, 32'h0, 4'hf, rd);  chk("post_rst_seed0", rd, 32'h0);

    // Last-seed write: starts a load only with auto-commit.
    ready_mode = 1; idle(1);
    xfer(1'b0, 6'd3, 32'h55, 4'hf, rd);
    chk("auto_commit_busy", 32'(busy), 32'(AUTO));
    drain();

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      ready_mode = $urandom_range(0, 3) == 0 ? 1 : 0;
      r = $urandom_range(0, 9);
      d = $urandom;
      case (r)
        0, 1, 2, 3, 8: w = 6'($urandom_range(0, N - 1));
        4, 9:          begin w = 6'd16; d = {$urandom_range(0, 65535), 14'h0, 2'($urandom_range(0, 3))}; end
        5:             w = 6'd17;
        6:             w = 6'($urandom_range(N, 15));
        default:       w = 6'($urandom_range(18, 63));
      endcase
      xfer(1'($urandom_range(0, 1)), w, d, 4'($urandom_range(0, 15)), rd);
      idle($urandom_range(0, 2));
    end
    drain();
    xfer(1'b1, 6'd17, 32'h0, 4'hf, rd);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
